// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared constants and types for the fetch sequencer slice.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int PC_W       = 13;
    localparam int INSTR_W    = 32;
    localparam int IMEM_DEPTH = 8192;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_word_t;

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_skid_buf
// Description : Single-entry skid register for one {instr, pc} fetch word.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_unload,
    input  logic        i_clear,
    input  fetch_word_t i_word,
    output fetch_word_t o_word,
    output logic        o_full
);

    fetch_word_t r_word;
    logic        r_full;

    // Clear wins so a redirect can never leave a stale word behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word <= '0;
            r_full <= 1'b0;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_word <= i_word;
            r_full <= 1'b1;
        end else if (i_unload) begin
            r_full <= 1'b0;
        end
    end

    assign o_word = r_word;
    assign o_full = r_full;

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Fetch-stage PC owner, imem sequencer and valid/stall delivery
//               with a one-entry skid. FETCH_PERF_EN adds perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int PC_W     = 13,
    parameter int INSTR_W  = 32,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_W:0]      prog_size_i,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic               imem_rd_en_o,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic [INSTR_W-1:0] imem_data_i,
    output logic               instr_valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    instr_pc_o,
    output logic               halted_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetch_cnt_o,
    output logic [31:0]        perf_stall_cnt_o
`endif
);

    import fetch_pkg::*;

    localparam logic [PC_W:0] c_reset_pc = (PC_W+1)'(RESET_PC);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [PC_W:0]   r_pc;
    logic            r_pend;
    logic [PC_W-1:0] r_pend_pc;
    logic            r_out_valid;
    fetch_word_t     r_out;

    fetch_word_t     w_skid_word;
    fetch_word_t     w_ret_word;
    logic            w_skid_full;
    logic            w_accept;
    logic            w_out_free;
    logic            w_in_range;
    logic            w_issue;
    logic            w_ret;
    logic            w_skid_load;
    logic            w_skid_unload;

    always_comb begin
        w_accept      = r_out_valid & ~stall_i;
        w_out_free    = ~r_out_valid | w_accept;
        w_in_range    = (r_pc < prog_size_i);
        w_issue       = (r_state == RUN) & w_in_range & ~redirect_i & ~w_skid_full
                        & (~stall_i | ~r_out_valid);
        w_ret         = r_pend & ~redirect_i;
        w_skid_load   = w_ret & ~w_out_free;
        w_skid_unload = w_accept & w_skid_full;
        w_ret_word.instr = imem_data_i;
        w_ret_word.pc    = r_pend_pc;
    end

    // Halting waits for every buffered word to leave, so halted_o implies drained.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: w_state_nxt = RUN;
            RUN: begin
                if (!redirect_i && !w_in_range && !r_pend && !w_skid_full && w_out_free)
                    w_state_nxt = HALT;
            end
            HALT: begin
                if (redirect_i && ({1'b0, redirect_pc_i} < prog_size_i))
                    w_state_nxt = RUN;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pc        <= c_reset_pc;
            r_pend      <= 1'b0;
            r_pend_pc   <= '0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (redirect_i) begin
                r_pc        <= {1'b0, redirect_pc_i};
                r_pend      <= 1'b0;
                r_out_valid <= 1'b0;
            end else begin
                r_pend <= w_issue;
                if (w_issue) begin
                    r_pc      <= r_pc + 1'b1;
                    r_pend_pc <= r_pc[PC_W-1:0];
                end
                // The skid is always older than a returning read, so it drains first.
                if (w_skid_unload) begin
                    r_out       <= w_skid_word;
                    r_out_valid <= 1'b1;
                end else if (w_ret && w_out_free) begin
                    r_out       <= w_ret_word;
                    r_out_valid <= 1'b1;
                end else if (w_accept) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    fetch_skid_buf u_skid (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_skid_load),
        .i_unload (w_skid_unload),
        .i_clear  (redirect_i),
        .i_word   (w_ret_word),
        .o_word   (w_skid_word),
        .o_full   (w_skid_full)
    );

    assign imem_rd_en_o  = w_issue;
    assign imem_addr_o   = r_pc[PC_W-1:0];
    assign instr_valid_o = r_out_valid;
    assign instr_o       = r_out.instr;
    assign instr_pc_o    = r_out.pc;
    assign halted_o      = (r_state == HALT);

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetch <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_accept && (r_perf_fetch != '1))
                r_perf_fetch <= r_perf_fetch + 1'b1;
            if (r_out_valid && stall_i && (r_perf_stall != '1))
                r_perf_stall <= r_perf_stall + 1'b1;
        end
    end

    assign perf_fetch_cnt_o = r_perf_fetch;
    assign perf_stall_cnt_o = r_perf_stall;
`endif

endmodule
`default_nettype wire
